// File: rtl/sample_player_pkg.sv
// Shared types and default widths for the sample playback sequencer.
package sample_player_pkg;

    localparam int unsigned DefaultDataWidth    = 8;
    localparam int unsigned DefaultAddressWidth = 8;
    localparam int unsigned DefaultDividerWidth = 16;
    localparam int unsigned VolumeWidth         = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StFetch,
        StDrain
    } state_e;

endpackage

// File: rtl/sample_player_tick.sv
// tick_divider: loadable up-counter that flags and self-clears on reaching a terminal value.
module tick_divider
    import sample_player_pkg::*;
#(
    parameter int unsigned Width = DefaultDividerWidth
) (
    input  logic             i_CLK,
    input  logic             i_NRESET,
    input  logic             i_Clear,
    input  logic             i_Enable,
    input  logic [Width-1:0] i_Terminal,
    output logic             o_TerminalCount
);

    logic [Width-1:0] count_q, count_d;

    assign o_TerminalCount = i_Enable && (count_q == i_Terminal);

    always_comb begin
        count_d = count_q;
        if (i_Clear || o_TerminalCount) begin
            count_d = '0;
        end else if (i_Enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_player.sv
// Tick-driven RAM playback sequencer with a valid/ready sample stream.
// Optional SAMPLE_PLAYER_VOLUME_EN adds an i_Volume scaler in the capture path.
module sample_player
    import sample_player_pkg::*;
#(
    parameter int unsigned DataWidth    = DefaultDataWidth,
    parameter int unsigned AddressWidth = DefaultAddressWidth,
    parameter int unsigned DividerWidth = DefaultDividerWidth
) (
    input  logic                    i_CLK,
    input  logic                    i_NRESET,
    input  logic                    i_START,
    input  logic                    i_STOP,
    input  logic                    i_LOOP,
    input  logic [AddressWidth-1:0] i_StartAddress,
    input  logic [AddressWidth-1:0] i_EndAddress,
    input  logic [DividerWidth-1:0] i_Divider,
`ifdef SAMPLE_PLAYER_VOLUME_EN
    input  logic [VolumeWidth-1:0]  i_Volume,
`endif
    output logic                    o_RamEnable,
    output logic                    o_RamWE,
    output logic [AddressWidth-1:0] o_RamAddress,
    input  logic [DataWidth-1:0]    i_RamData,
    output logic [DataWidth-1:0]    o_Sample,
    output logic                    o_SampleValid,
    input  logic                    i_SampleReady,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_MISS
);

    state_e                  state_q, state_d;
    logic                    loop_q, loop_d;
    logic [AddressWidth-1:0] start_q, start_d;
    logic [AddressWidth-1:0] end_q, end_d;
    logic [DividerWidth-1:0] divider_q, divider_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    miss_q, miss_d;
    logic                    tick;
    logic                    start_ok;
    logic [DataWidth-1:0]    capture;

    assign start_ok = i_START && !i_STOP && (state_q == StIdle);

    tick_divider #(
        .Width (DividerWidth)
    ) u_tick_divider (
        .i_CLK           (i_CLK),
        .i_NRESET        (i_NRESET),
        .i_Clear         ((state_q != StWait) || i_STOP),
        .i_Enable        (state_q == StWait),
        .i_Terminal      (divider_q),
        .o_TerminalCount (tick)
    );

`ifdef SAMPLE_PLAYER_VOLUME_EN
    logic [VolumeWidth-1:0]           volume_q;
    logic [DataWidth+VolumeWidth-1:0] scaled;

    // Upper DataWidth bits of the product are exactly (data * volume) >> 8.
    assign scaled  = (DataWidth+VolumeWidth)'(i_RamData) * (DataWidth+VolumeWidth)'(volume_q);
    assign capture = scaled[DataWidth+VolumeWidth-1:VolumeWidth];

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            volume_q <= '0;
        end else if (start_ok) begin
            volume_q <= i_Volume;
        end
    end
`else
    assign capture = i_RamData;
`endif

    always_comb begin
        state_d   = state_q;
        loop_d    = loop_q;
        start_d   = start_q;
        end_d     = end_q;
        divider_d = divider_q;
        addr_d    = addr_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        miss_d    = miss_q;
        o_DONE    = 1'b0;

        if (valid_q && i_SampleReady) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    loop_d    = i_LOOP;
                    start_d   = i_StartAddress;
                    end_d     = i_EndAddress;
                    divider_d = i_Divider;
                    addr_d    = i_StartAddress;
                    miss_d    = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (tick) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                sample_d = capture;
                valid_d  = 1'b1;
                // An unaccepted sample is being overwritten.
                if (valid_q && !i_SampleReady) begin
                    miss_d = 1'b1;
                end
                if (addr_q != end_q) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StWait;
                end else if (loop_q) begin
                    addr_d  = start_q;
                    state_d = StWait;
                end else begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!valid_q) begin
                    o_DONE  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stop overrides everything, including a pending DONE.
        if (i_STOP) begin
            state_d = StIdle;
            valid_d = 1'b0;
            o_DONE  = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state_q   <= StIdle;
            loop_q    <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            divider_q <= '0;
            addr_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            loop_q    <= loop_d;
            start_q   <= start_d;
            end_q     <= end_d;
            divider_q <= divider_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            miss_q    <= miss_d;
        end
    end

    assign o_RamEnable   = (state_q == StFetch);
    assign o_RamWE       = 1'b0;
    assign o_RamAddress  = addr_q;
    assign o_Sample      = sample_q;
    assign o_SampleValid = valid_q;
    assign o_BUSY        = (state_q != StIdle);
    assign o_MISS        = miss_q;

endmodule
